// File: rtl/breath_pkg.sv
// breath_pkg: shared definitions for the breath-LED mode path.
//   mode_t          - breath pattern select (SLOW/MID/FAST active, AFK1/AFK2 idle)
//   DEF_*           - default timing parameters at 12 MHz
//   cnt_w()         - counter width for a terminal count, never below 1 bit
//   next_active()   - active-mode rotation SLOW->MID->FAST->SLOW
//   is_afk()        - true for either AFK phase
package breath_pkg;

    typedef enum logic [2:0] {
        MODE_SLOW = 3'd0,
        MODE_MID  = 3'd1,
        MODE_FAST = 3'd2,
        MODE_AFK1 = 3'd3,
        MODE_AFK2 = 3'd4
    } mode_t;

    localparam int DEF_DEBOUNCE_CYC   = 240000;     // 20 ms
    localparam int DEF_IDLE_CYC       = 360000000;  // 30 s
    localparam int DEF_AFK_TOGGLE_CYC = 24000000;   // 2 s

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Anything outside the active set folds back to SLOW so a corrupted
    // mode can never propagate an illegal encoding.
    function automatic mode_t next_active(input mode_t m);
        case (m)
            MODE_SLOW: return MODE_MID;
            MODE_MID:  return MODE_FAST;
            default:   return MODE_SLOW;
        endcase
    endfunction

    function automatic logic is_afk(input mode_t m);
        return (m == MODE_AFK1) || (m == MODE_AFK2);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchroniser, stable-level debounce and press pulse.
//   clk       - system clock
//   rst       - synchronous active-low reset
//   key_n     - raw asynchronous button, low = pressed
//   key_press - one-cycle pulse per accepted press (debounced 1->0 only)
module key_debounce
    import breath_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic key_press
);

    localparam int            CW       = cnt_w(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic [1:0]    sync_pipe;   // sync_pipe[1] is the synchronised level
    logic          level;       // debounced level
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_pipe <= 2'b11;
            level     <= 1'b1;
            cnt       <= '0;
            key_press <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[0], key_n};
            key_press <= 1'b0;
            if (sync_pipe[1] == level) begin
                // Any agreement restarts the stability window.
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Differed for DEBOUNCE_CYC consecutive cycles: accept.
                level     <= sync_pipe[1];
                cnt       <= '0;
                key_press <= ~sync_pipe[1];
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/breath_mode_ctrl.sv
// breath_mode_ctrl: button-driven breath-pattern selector with AFK idle mode.
//   clk      - 12 MHz system clock
//   rst      - synchronous active-low reset
//   key_n    - raw mode button, low = pressed
//   mode     - registered pattern select (SLOW=0, MID=1, FAST=2, AFK1=3, AFK2=4)
//   mode_chg - one-cycle pulse in the cycle mode takes a new value
//   afk      - high while mode is AFK1 or AFK2
//   key_press- one-cycle pulse per accepted press
module breath_mode_ctrl
    import breath_pkg::*;
#(
    parameter int DEBOUNCE_CYC   = DEF_DEBOUNCE_CYC,
    parameter int IDLE_CYC       = DEF_IDLE_CYC,
    parameter int AFK_TOGGLE_CYC = DEF_AFK_TOGGLE_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_n,
    output logic [2:0] mode,
    output logic       mode_chg,
    output logic       afk,
    output logic       key_press
);

    localparam int            IW         = cnt_w(IDLE_CYC);
    localparam int            PW         = cnt_w(AFK_TOGGLE_CYC);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_CYC - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(AFK_TOGGLE_CYC - 1);

    mode_t         state, state_nx;
    mode_t         saved, saved_nx;     // active mode to restore on AFK exit
    logic [IW-1:0] idle_cnt, idle_nx;
    logic [PW-1:0] phase_cnt, phase_nx;

    key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_key_debounce (
        .clk      (clk),
        .rst      (rst),
        .key_n    (key_n),
        .key_press(key_press)
    );

    assign mode = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= MODE_SLOW;
            saved     <= MODE_SLOW;
            idle_cnt  <= '0;
            phase_cnt <= '0;
            mode_chg  <= 1'b0;
            afk       <= 1'b0;
        end else begin
            state     <= state_nx;
            saved     <= saved_nx;
            idle_cnt  <= idle_nx;
            phase_cnt <= phase_nx;
            // Derived from the next state so both flags line up with mode.
            mode_chg  <= (state_nx != state);
            afk       <= is_afk(state_nx);
        end
    end

    always_comb begin
        state_nx = state;
        saved_nx = saved;
        idle_nx  = idle_cnt;
        phase_nx = phase_cnt;
        case (state)
            MODE_AFK1, MODE_AFK2: begin
                idle_nx = '0;
                if (key_press) begin
                    // Exit wins over a coinciding phase toggle.
                    state_nx = saved;
                    phase_nx = '0;
                end else if (phase_cnt == PHASE_LAST) begin
                    state_nx = (state == MODE_AFK1) ? MODE_AFK2 : MODE_AFK1;
                    phase_nx = '0;
                end else begin
                    phase_nx = phase_cnt + PW'(1);
                end
            end
            default: begin
                phase_nx = '0;
                if (key_press) begin
                    // A press on the expiry cycle advances instead of idling.
                    state_nx = next_active(state);
                    idle_nx  = '0;
                end else if (idle_cnt == IDLE_LAST) begin
                    state_nx = MODE_AFK1;
                    saved_nx = state;
                    idle_nx  = '0;
                end else begin
                    idle_nx = idle_cnt + IW'(1);
                end
            end
        endcase
    end

endmodule
